pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value loaded at reset.
REQ-003 SHALL have parameter STEP, default 4: sequential increment, power of two, at least 1.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return-address stack entries, at least 2.
REQ-005 SHALL have clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have enable  in  1  active-low advance enable: 0 = may advance, 1 = hold PC.
REQ-008 SHALL have imem_ready  in  1  instruction memory accepts pc_out this cycle.
REQ-009 SHALL have redirect_valid  in  1  branch or jump redirect request.
REQ-010 SHALL have redirect_target  in  WIDTH  redirect destination.
REQ-011 SHALL have call  in  1  the instruction at pc_out is a call.
REQ-012 SHALL have ret  in  1  the instruction at pc_out is a return.
REQ-013 SHALL have pc_out  out  WIDTH  current fetch address.
REQ-014 SHALL have pc_valid  out  1  pc_out is valid for fetch.
REQ-015 SHALL have ras_empty, ras_full, ras_underflow  out  1 each  stack status.

Function
REQ-016 SHALL implement states BOOT and RUN: pc_valid=0 in BOOT and 1 in RUN; BOOT goes to RUN after exactly one clock following rst_n release.
REQ-017 SHALL define fire = pc_valid AND imem_ready AND NOT enable.
REQ-018 SHALL select next PC by priority:
- redirect_valid: target with its low log2(STEP) bits forced to 0;
- else ret AND fire AND stack non-empty: popped stack top;
- else fire: pc_out + STEP;
- else: hold pc_out.
REQ-019 SHALL honour redirect_valid regardless of enable, imem_ready or state; a redirect in BOOT also moves the state to RUN.
REQ-020 SHALL compute pc_out + STEP modulo 2^WIDTH (wrap to 0, no flag).
REQ-021 SHALL ignore call and ret when fire=0 or redirect_valid=1.
REQ-022 SHALL, on call AND fire, push pc_out + STEP onto the stack.
REQ-023 SHALL, when pushing to a full stack, overwrite the oldest entry; count stays at RAS_DEPTH.
REQ-024 SHALL, on call AND ret in the same fire cycle, return the popped top as next PC and replace the top with pc_out + STEP; count is unchanged.
REQ-025 SHALL, on ret AND fire with an empty stack, advance sequentially and pulse ras_underflow for exactly one cycle.
REQ-026 SHALL drive ras_empty = (count==0) and ras_full = (count==RAS_DEPTH) combinationally from registered count.
REQ-027 SHALL give next-PC latency of one clock: pc_out updates on the edge following the qualifying condition.

Reset
REQ-028 SHALL, while rst_n=0, force pc_out=RESET_VECTOR, pc_valid=0, state=BOOT, stack count=0, ras_underflow=0 and ras_empty=1 asynchronously.
REQ-029 SHALL discard all stack contents and any in-progress redirect when rst_n asserts mid-operation.

Configuration
REQ-030 SHALL include the return-address stack only when macro PC_FETCH_RAS_EN is defined.
REQ-031 SHALL, without PC_FETCH_RAS_EN, keep all ports, ignore call and ret, and tie ras_empty=1, ras_full=0, ras_underflow=0; next PC is redirect, else sequential, else hold.

Verification
REQ-032 SHALL cover: reset with RESET_VECTOR=0x100, release, enable=0, imem_ready=1 -> pc_valid=0 for one cycle, then pc_out 0x100, 0x104, 0x108.
REQ-033 SHALL cover: enable=1 for 3 cycles at pc 0x108, then redirect_valid with target 0x2003 while enable=1 -> pc_out holds 0x108, then becomes 0x2000 next cycle.
REQ-034 SHALL cover: pc_out=0xFFFFFFFC with fire -> pc_out=0x00000000.
REQ-035 SHALL cover (macro on): call at 0x40, 0x80, 0xC0, 0x100, 0x140 with RAS_DEPTH=4, then 5 rets -> targets 0x144, 0x104, 0xC4, 0x84; fifth ret gives sequential PC and a one-cycle ras_underflow.
REQ-036 SHALL cover: call and ret together at 0x200 with top 0x500 -> next pc 0x500, top becomes 0x204, count unchanged.
REQ-037 SHALL cover: rst_n asserted mid-stream with 3 stack entries -> immediate pc_out=RESET_VECTOR, pc_valid=0, ras_empty=1.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: BOOT/RUN sequencing, redirects, sequential advance,
// and an optional return-address stack enabled by the macro PC_FETCH_RAS_EN.
module pc_fetch_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             imem_ready,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow,
    output logic             dbg_state
);

    // Handshake: an address is taken only when pc_valid and imem_ready are both
    // high and the active-low enable is 0 in the same cycle (fire).

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] redir_pc;
    logic             fire;

    assign pc_valid  = (state_q == RUN);
    assign dbg_state = state_q;
    assign pc_out    = pc_q;
    assign fire      = pc_valid & imem_ready & ~enable;
    assign seq_pc    = pc_q + STEP_W;
    assign redir_pc  = redirect_target & ALIGN_MASK;

    // A redirect during BOOT lands in RUN as well, which the unconditional
    // BOOT->RUN transition already provides.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_FETCH_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d, top_inc, top_dec, wr_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uf_q, uf_d;
    logic             stk_empty, stk_full;
    logic             op_push, op_pop, wr_en;
    logic [WIDTH-1:0] ras_top;

    assign stk_empty = (cnt_q == '0);
    assign stk_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign op_push   = fire & ~redirect_valid & call;
    assign op_pop    = fire & ~redirect_valid & ret & ~stk_empty;
    assign top_inc   = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
    assign top_dec   = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);
    assign ras_top   = ras_mem_q[top_q];

    // Circular storage: a push onto a full stack advances over the oldest slot.
    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = top_q;
        uf_d   = fire & ~redirect_valid & ret & stk_empty;
        if (op_push && op_pop) begin
            wr_en  = 1'b1;
            wr_ptr = top_q;
        end else if (op_pop) begin
            top_d = top_dec;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (op_push) begin
            wr_en  = 1'b1;
            wr_ptr = top_inc;
            top_d  = top_inc;
            if (!stk_full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redir_pc;
        end else if (op_pop) begin
            pc_d = ras_top;
        end else if (fire) begin
            pc_d = seq_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= PTR_W'(RAS_DEPTH - 1);
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

    // Entry contents need no reset: a zero count makes them unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem_q[wr_ptr] <= seq_pc;
        end
    end

    assign ras_empty     = stk_empty;
    assign ras_full      = stk_full;
    assign ras_underflow = uf_q;
`else
    logic unused_ras_inputs;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redir_pc;
        end else if (fire) begin
            pc_d = seq_pc;
        end
    end

    assign unused_ras_inputs = &{1'b0, call, ret, (RAS_DEPTH > 1)};
    assign ras_empty         = 1'b1;
    assign ras_full          = 1'b0;
    assign ras_underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model (stack behaviour follows PC_FETCH_RAS_EN).
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, imem_ready, redirect_valid, call, ret;
    logic [31:0] redirect_target;
    logic [31:0] pc_out;
    logic        pc_valid, ras_empty, ras_full, ras_underflow, dbg_state;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    bit          m_run;
    bit          m_uf;
    logic [31:0] m_stk[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .WIDTH(32), .RESET_VECTOR(RV), .STEP(4), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .imem_ready(imem_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .call(call), .ret(ret), .pc_out(pc_out), .pc_valid(pc_valid),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = RV;
        m_run = 1'b0;
        m_uf  = 1'b0;
        m_stk.delete();
    endtask

    // Reference behaviour for one rising edge, using the inputs currently driven.
    task automatic model_edge();
        bit          fire;
        bit          was_empty;
        logic [31:0] seq;
        fire = m_run && imem_ready && !enable;
        seq  = m_pc + 32'd4;
        m_uf = 1'b0;
        if (redirect_valid) begin
            m_pc = redirect_target & 32'hFFFF_FFFC;
        end else if (fire) begin
`ifdef PC_FETCH_RAS_EN
            was_empty = (m_stk.size() == 0);
            if (ret && !was_empty) begin
                m_pc = m_stk[m_stk.size() - 1];
                if (call) m_stk[m_stk.size() - 1] = seq;
                else void'(m_stk.pop_back());
            end else begin
                m_pc = seq;
                if (call) begin
                    m_stk.push_back(seq);
                    if (m_stk.size() > 4) void'(m_stk.pop_front());
                end
                m_uf = ret && was_empty;
            end
`else
            was_empty = 1'b1;
            m_pc = seq;
`endif
        end
        m_run = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, pc_out, m_pc);
        chk({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, m_run});
        chk({tag, ".state"}, {31'b0, dbg_state}, {31'b0, m_run});
`ifdef PC_FETCH_RAS_EN
        chk({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, m_stk.size() == 0});
        chk({tag, ".full"}, {31'b0, ras_full}, {31'b0, m_stk.size() == 4});
        chk({tag, ".uf"}, {31'b0, ras_underflow}, {31'b0, m_uf});
`else
        chk({tag, ".empty"}, {31'b0, ras_empty}, 32'd1);
        chk({tag, ".full"}, {31'b0, ras_full}, 32'd0);
        chk({tag, ".uf"}, {31'b0, ras_underflow}, 32'd0);
`endif
    endtask

    task automatic drive(input logic en, input logic rdy, input logic rv,
                         input logic [31:0] tgt, input logic c, input logic r);
        enable          = en;
        imem_ready      = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        call            = c;
        ret             = r;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [31:0] call_addr [5];
        logic [31:0] ret_exp [5];
        call_addr = '{32'h40, 32'h80, 32'hC0, 32'h100, 32'h140};
        ret_exp   = '{32'h144, 32'h104, 32'hC4, 32'h84, 32'h88};

        // Reset and boot
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_model("rst");
        chk("rst_pc", pc_out, RV);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("boot_valid", {31'b0, pc_valid}, 32'd0);
        cycle("boot");
        chk("run_pc0", pc_out, 32'h100);
        chk("run_valid", {31'b0, pc_valid}, 32'd1);
        cycle("seq1");
        chk("seq_pc1", pc_out, 32'h104);
        cycle("seq2");
        chk("seq_pc2", pc_out, 32'h108);

        // Hold with enable=1, then redirect while still held
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("hold");
            chk("hold_pc", pc_out, 32'h108);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h2003, 1'b0, 1'b0);
        chk("pre_redir", pc_out, 32'h108);
        cycle("redir");
        chk("redir_pc", pc_out, 32'h2000);

        // Wrap at top of address space
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cycle("wrap_set");
        chk("wrap_top", pc_out, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle("wrap");
        chk("wrap_pc", pc_out, 32'h0);

        // Five calls into a four-deep stack, then five returns
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, call_addr[i], 1'b0, 1'b0);
            cycle("call_at");
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            cycle("call");
        end
`ifdef PC_FETCH_RAS_EN
        chk("ras_full5", {31'b0, ras_full}, 32'd1);
`endif
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle("ret");
`ifdef PC_FETCH_RAS_EN
            chk("ret_pc", pc_out, ret_exp[i]);
            chk("ret_uf", {31'b0, ras_underflow}, {31'b0, i == 4});
`endif
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle("uf_drop");
        chk("uf_pulse_end", {31'b0, ras_underflow}, 32'd0);

        // Call and return in the same cycle
        drive(1'b0, 1'b1, 1'b1, 32'h4FC, 1'b0, 1'b0);
        cycle("cr_set");
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("cr_push");
        drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        cycle("cr_at");
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle("cr_both");
`ifdef PC_FETCH_RAS_EN
        chk("cr_pc", pc_out, 32'h500);
        chk("cr_empty", {31'b0, ras_empty}, 32'd0);
`endif
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("cr_ret");
`ifdef PC_FETCH_RAS_EN
        chk("cr_top", pc_out, 32'h204);
        chk("cr_drained", {31'b0, ras_empty}, 32'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            cycle("rand");
        end

        // Asynchronous reset with three stacked returns outstanding
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        #3;
        check_model("rst2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("boot2");
        drive(1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b0);
        cycle("mid_at");
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("mid_call");
        drive(1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("mid_rst");
        chk("mid_rst_pc", pc_out, RV);
        chk("mid_rst_empty", {31'b0, ras_empty}, 32'd1);
        @(posedge clk);
        #1;
        chk("mid_rst_hold", pc_out, RV);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("post_boot");
        cycle("post_ret");
`ifdef PC_FETCH_RAS_EN
        chk("post_uf", {31'b0, ras_underflow}, 32'd1);
`endif
        chk("post_pc", pc_out, 32'h104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
